// File: rtl/adc_pkg.sv
// Shared types and sizing helpers for the ADC averaging path.
package adc_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } avg_state_t;

    localparam int MAX_LOG2_AVG_DEFAULT = 8;

    // Accumulator must hold 2^max_log2_avg full-scale samples without wrapping.
    function automatic int acc_width(input int data_width, input int max_log2_avg);
        return data_width + max_log2_avg;
    endfunction

endpackage

// File: rtl/adc_averager_if.sv
// Valid/ready sample stream; master drives data, slave drives ready.
interface adc_averager_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adc_avg_accum.sv
// Window accumulator: sums 2^n signed samples and reports the floored mean
// combinationally on the cycle the final sample of the window is accepted.
module adc_avg_accum
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_LOG2_AVG = MAX_LOG2_AVG_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_flush,
    input  logic                  i_sample_valid,
    input  logic [DATA_WIDTH-1:0] i_sample,
    input  logic [3:0]            i_log2_avg,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);
    localparam int         ACC_W = acc_width(DATA_WIDTH, MAX_LOG2_AVG);
    localparam int         CNT_W = MAX_LOG2_AVG + 1;
    localparam logic [3:0] MAX_N = 4'(MAX_LOG2_AVG);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_n;

    logic             w_first;
    logic [3:0]       w_clamped;
    logic [3:0]       w_n;
    logic [ACC_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_target;

    // Window arithmetic; the window size is frozen by the first sample.
    always_comb begin
        w_first    = (r_cnt == {CNT_W{1'b0}});
        w_clamped  = (i_log2_avg > MAX_N) ? MAX_N : i_log2_avg;
        w_n        = w_first ? w_clamped : r_n;
        w_sum      = r_acc + {{MAX_LOG2_AVG{i_sample[DATA_WIDTH-1]}}, i_sample};
        w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        w_target   = {{(CNT_W-1){1'b0}}, 1'b1} << w_n;
        o_done     = i_sample_valid && (w_cnt_next == w_target);
        o_result   = DATA_WIDTH'($signed(w_sum) >>> w_n);
    end

    // Accumulator, window count and latched shift amount.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc <= {ACC_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
            r_n   <= 4'd0;
        end else if (i_flush) begin
            r_acc <= {ACC_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_sample_valid) begin
            if (w_first) begin
                r_n <= w_clamped;
            end
            if (o_done) begin
                r_acc <= {ACC_W{1'b0}};
                r_cnt <= {CNT_W{1'b0}};
            end else begin
                r_acc <= w_sum;
                r_cnt <= w_cnt_next;
            end
        end
    end

endmodule

// File: rtl/adc_averager.sv
// Boxcar averager for the ADC sample stream with framed, single-entry output.
// Optional feature macro: ADC_AVERAGER_DROP_COUNT_EN adds a saturating drop_count output.
module adc_averager
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_LOG2_AVG = MAX_LOG2_AVG_DEFAULT
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         enable,
    input  logic [3:0]   log2_avg,
    input  logic [15:0]  frame_len,
    adc_averager_if.slave  s_axis,
    adc_averager_if.master m_axis,
    output logic         overflow
`ifdef ADC_AVERAGER_DROP_COUNT_EN
    ,
    output logic [15:0]  drop_count
`endif
);
    avg_state_t            r_state;
    logic                  r_enable_d;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_last;
    logic [15:0]           r_frame_cnt;
    logic [15:0]           r_frame_len;
    logic                  r_overflow;

    logic                  w_accept;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_out_hs;
    logic                  w_load;
    logic                  w_drop;
    logic [15:0]           w_len_in;
    logic [15:0]           w_len;
    logic                  w_last;
    logic                  w_en_rise;

    // The ADC cannot be stalled, so ready follows reset only.
    assign s_axis.tready = resetn;
    assign m_axis.tvalid = r_m_valid;
    assign m_axis.tdata  = r_m_data;
    assign m_axis.tlast  = r_m_last;
    assign overflow      = r_overflow;
    assign w_accept      = (r_state == ST_ACC) && enable && s_axis.tvalid;

    adc_avg_accum #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MAX_LOG2_AVG(MAX_LOG2_AVG)
    ) u_accum (
        .clk           (clk),
        .resetn        (resetn),
        .i_flush       (!enable),
        .i_sample_valid(w_accept),
        .i_sample      (s_axis.tdata),
        .i_log2_avg    (log2_avg),
        .o_done        (w_done),
        .o_result      (w_result)
    );

    // A finished window may reuse the output slot if it empties this cycle.
    always_comb begin
        w_out_hs  = r_m_valid && m_axis.tready;
        w_load    = w_done && (!r_m_valid || w_out_hs);
        w_drop    = w_done && !w_load;
        w_len_in  = (frame_len == 16'd0) ? 16'd1 : frame_len;
        w_len     = (r_frame_cnt == 16'd0) ? w_len_in : r_frame_len;
        w_last    = (({1'b0, r_frame_cnt} + 17'd1) == {1'b0, w_len});
        w_en_rise = enable && !r_enable_d;
    end

    // Run/idle FSM, framing counter, output register and sticky overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_enable_d  <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= {DATA_WIDTH{1'b0}};
            r_m_last    <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_frame_len <= 16'd1;
            r_overflow  <= 1'b0;
        end else begin
            r_enable_d <= enable;
            case (r_state)
                ST_IDLE: if (enable)  r_state <= ST_ACC;
                ST_ACC:  if (!enable) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if (!enable) begin
                r_frame_cnt <= 16'd0;
            end else if (w_load) begin
                if (r_frame_cnt == 16'd0) begin
                    r_frame_len <= w_len_in;
                end
                r_frame_cnt <= w_last ? 16'd0 : (r_frame_cnt + 16'd1);
            end

            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_result;
                r_m_last  <= w_last;
            end else if (w_out_hs) begin
                r_m_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_en_rise) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef ADC_AVERAGER_DROP_COUNT_EN
    logic [15:0] r_drop_cnt;

    assign drop_count = r_drop_cnt;

    // Saturating count of dropped results, cleared alongside overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop) begin
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end else if (w_en_rise) begin
            r_drop_cnt <= 16'd0;
        end
    end
`endif

endmodule

// File: tb/tb_adc_averager.sv
// Directed bench for adc_averager with hand-computed expected results.
module tb_adc_averager;

    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [3:0]  log2_avg;
    logic [15:0] frame_len;
    logic        overflow;
`ifdef ADC_AVERAGER_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    adc_averager_if #(.DATA_WIDTH(DW)) s_if ();
    adc_averager_if #(.DATA_WIDTH(DW)) m_if ();

    adc_averager #(
        .DATA_WIDTH  (DW),
        .MAX_LOG2_AVG(8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .log2_avg  (log2_avg),
        .frame_len (frame_len),
        .s_axis    (s_if.slave),
        .m_axis    (m_if.master),
        .overflow  (overflow)
`ifdef ADC_AVERAGER_DROP_COUNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v);
        s_if.tdata  = v;
        s_if.tvalid = 1'b1;
        tick();
        s_if.tvalid = 1'b0;
    endtask

    task automatic start(input logic [3:0] l, input logic [15:0] f);
        log2_avg  = l;
        frame_len = f;
        enable    = 1'b1;
        tick();
    endtask

    task automatic stop();
        enable = 1'b0;
        tick();
        tick();
    endtask

    logic [31:0] vals [7];
    logic        lasts[7];

    initial begin
        resetn      = 1'b0;
        enable      = 1'b0;
        log2_avg    = 4'd0;
        frame_len   = 16'd1;
        s_if.tdata  = 32'd0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        tick();
        tick();
        check_eq("rst_valid", 64'(m_if.tvalid), 64'd0);
        check_eq("rst_data", 64'(m_if.tdata), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        check_eq("rst_s_ready", 64'(s_if.tready), 64'd0);
        resetn = 1'b1;
        tick();
        check_eq("s_ready_high", 64'(s_if.tready), 64'd1);

        // Mean of 4,8,12,16 appears the cycle after the fourth sample
        start(4'd2, 16'd1);
        send(32'd4); send(32'd8); send(32'd12);
        check_eq("avg4_not_yet", 64'(m_if.tvalid), 64'd0);
        send(32'd16);
        check_eq("avg4_valid", 64'(m_if.tvalid), 64'd1);
        check_eq("avg4_data", 64'(m_if.tdata), 64'd10);
        check_eq("avg4_last", 64'(m_if.tlast), 64'd1);
        tick();
        check_eq("avg4_drained", 64'(m_if.tvalid), 64'd0);
        stop();

        // Floor truncation of a negative mean
        start(4'd1, 16'd1);
        send(32'hFFFF_FFFD); send(32'hFFFF_FFFC);
        check_eq("neg_floor", 64'(m_if.tdata), 64'hFFFF_FFFC);
        stop();

        // Full-scale 256-sample window must not wrap
        start(4'd8, 16'd1);
        for (int i = 0; i < 255; i++) send(32'h7FFF_FFFF);
        check_eq("full_not_yet", 64'(m_if.tvalid), 64'd0);
        send(32'h7FFF_FFFF);
        check_eq("full_scale", 64'(m_if.tdata), 64'h7FFF_FFFF);
        stop();

        // log2_avg=15 clamps to 8: mean of 0..255 floors to 127
        start(4'd15, 16'd1);
        for (int i = 0; i < 255; i++) send(32'(i));
        check_eq("clamp_not_yet", 64'(m_if.tvalid), 64'd0);
        send(32'd255);
        check_eq("clamp_data", 64'(m_if.tdata), 64'd127);
        stop();

        // Window size change mid-window is ignored
        start(4'd1, 16'd1);
        send(32'd2);
        log2_avg = 4'd2;
        send(32'd4);
        check_eq("midwin_valid", 64'(m_if.tvalid), 64'd1);
        check_eq("midwin_data", 64'(m_if.tdata), 64'd3);
        stop();

        // frame_len of 0 behaves as 1
        start(4'd0, 16'd0);
        send(32'd9);
        check_eq("flen0_last", 64'(m_if.tlast), 64'd1);
        stop();

        // Pass-through with frames of 3
        vals[0] = 32'd100; vals[1] = 32'hFFFF_FFFF; vals[2] = 32'd7; vals[3] = 32'd0;
        vals[4] = 32'h8000_0000; vals[5] = 32'd55; vals[6] = 32'd3;
        lasts[0] = 1'b0; lasts[1] = 1'b0; lasts[2] = 1'b1; lasts[3] = 1'b0;
        lasts[4] = 1'b0; lasts[5] = 1'b1; lasts[6] = 1'b0;
        start(4'd0, 16'd3);
        for (int i = 0; i < 7; i++) begin
            send(vals[i]);
            check_eq($sformatf("frame_data%0d", i), 64'(m_if.tdata), 64'(vals[i]));
            check_eq($sformatf("frame_last%0d", i), 64'(m_if.tlast), 64'(lasts[i]));
        end
        stop();

        // Backpressure: hold, drop, same-cycle reload, flush while pending
        m_if.tready = 1'b0;
        start(4'd0, 16'd3);
        send(32'd11);
        check_eq("bp_first", 64'(m_if.tdata), 64'd11);
        check_eq("bp_first_ovf", 64'(overflow), 64'd0);
        send(32'd22);
        check_eq("bp_held", 64'(m_if.tdata), 64'd11);
        check_eq("bp_held_last", 64'(m_if.tlast), 64'd0);
        check_eq("bp_ovf", 64'(overflow), 64'd1);
`ifdef ADC_AVERAGER_DROP_COUNT_EN
        check_eq("bp_drop_cnt", 64'(drop_count), 64'd1);
`endif
        m_if.tready = 1'b1;
        send(32'd33);
        m_if.tready = 1'b0;
        check_eq("same_cycle_data", 64'(m_if.tdata), 64'd33);
        check_eq("same_cycle_last", 64'(m_if.tlast), 64'd0);
`ifdef ADC_AVERAGER_DROP_COUNT_EN
        check_eq("same_cycle_drops", 64'(drop_count), 64'd1);
`endif
        enable = 1'b0;
        tick();
        tick();
        check_eq("pending_valid", 64'(m_if.tvalid), 64'd1);
        check_eq("pending_data", 64'(m_if.tdata), 64'd33);
        check_eq("ovf_sticky", 64'(overflow), 64'd1);
        m_if.tready = 1'b1;
        tick();
        check_eq("pending_taken", 64'(m_if.tvalid), 64'd0);
        start(4'd0, 16'd3);
        check_eq("ovf_cleared", 64'(overflow), 64'd0);
`ifdef ADC_AVERAGER_DROP_COUNT_EN
        check_eq("drops_cleared", 64'(drop_count), 64'd0);
`endif
        send(32'd66);
        check_eq("frame_restart", 64'(m_if.tlast), 64'd0);

        // Reset mid-window discards the partial sum
        log2_avg  = 4'd2;
        frame_len = 16'd1;
        tick();
        send(32'd1); send(32'd2);
        resetn = 1'b0;
        #2;
        check_eq("midrst_valid", 64'(m_if.tvalid), 64'd0);
        check_eq("midrst_data", 64'(m_if.tdata), 64'd0);
        check_eq("midrst_last", 64'(m_if.tlast), 64'd0);
        check_eq("midrst_s_ready", 64'(s_if.tready), 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        send(32'd5); send(32'd5); send(32'd5);
        check_eq("postrst_not_yet", 64'(m_if.tvalid), 64'd0);
        send(32'd5);
        check_eq("postrst_valid", 64'(m_if.tvalid), 64'd1);
        check_eq("postrst_data", 64'(m_if.tdata), 64'd5);
        stop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
